// File: rtl/adbg_crc_pkg.sv
// adbg_crc_pkg
//   Shared types and constants for the advanced-debug CRC engine.
//   - crc_state_e : engine state (ACCUM / SHIFT)
//   - CRC32_*     : default reflected CRC-32 constants
//   - crc_step()  : one-bit reflected CRC update, right-shifting register
package adbg_crc_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_SHIFT = 1'b1
  } crc_state_e;

  localparam logic [31:0] CRC32_POLY_REV      = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT          = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_CHECK_RESIDUE = 32'h340BC6D9;

  // Works for any CRC_W <= 32 as long as crc is zero-extended and poly is
  // masked to CRC_W bits: the upper bits then stay zero.
  function automatic logic [31:0] crc_step(input logic [31:0] crc,
                                           input logic        d,
                                           input logic [31:0] poly);
    logic fb;
    fb       = crc[0] ^ d;
    crc_step = (crc >> 1) ^ (fb ? poly : 32'h0);
  endfunction

endpackage

// File: rtl/adbg_crc_step.sv
// adbg_crc_step
//   Combinational DATA_W-bit unrolled CRC update, bit 0 of data absorbed first.
//   Ports:
//     crc_in  : current CRC register value
//     data    : data beat
//     crc_out : CRC after absorbing all DATA_W bits
module adbg_crc_step
  import adbg_crc_pkg::*;
#(
  parameter int unsigned CRC_W    = 32,
  parameter int unsigned DATA_W   = 1,
  parameter logic [31:0] POLY_REV = CRC32_POLY_REV
) (
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc_out
);

  localparam logic [31:0] POLY_M = POLY_REV & (32'hFFFFFFFF >> (32 - CRC_W));

  logic [31:0] acc;

  always_comb begin
    acc = 32'(crc_in);
    for (int i = 0; i < int'(DATA_W); i++) begin
      acc = crc_step(acc, data[i], POLY_M);
    end
    crc_out = acc[CRC_W-1:0];
  end

endmodule

// File: rtl/adbg_crc_engine.sv
// adbg_crc_engine
//   CRC generator/checker between the JTAG TAP shift path and the debug
//   module units. Accumulates a reflected CRC over accepted beats, then
//   shifts it out LSB-first or compares it bit-serially against cmp_bit.
//   Ports:
//     clk, rst_n              : clock, async active-low reset
//     clr                     : synchronous reinit, highest priority
//     in_valid/in_data/in_ready : data beat input (ready only in ACCUM)
//     shift_start, cmp_mode   : enter SHIFT, select compare or emit-only
//     shift_en, cmp_bit       : per-bit pacing and incoming CRC bit
//     serial_out, busy, done  : crc[0], in-SHIFT flag, end-of-shift pulse
//     crc_match, crc_out      : sticky compare result, live CRC register
//
//   state    | meaning
//   ST_ACCUM | absorbing beats, waiting for shift_start
//   ST_SHIFT | shifting CRC out / comparing, one bit per shift_en
module adbg_crc_engine
  import adbg_crc_pkg::*;
#(
  parameter int unsigned      CRC_W       = 32,
  parameter logic [31:0]      POLY_REV    = CRC32_POLY_REV,
  parameter logic [CRC_W-1:0] INIT        = {CRC_W{1'b1}},
  parameter int unsigned      DATA_W      = 1,
  parameter bit               AUTO_RELOAD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              shift_start,
  input  logic              cmp_mode,
  input  logic              shift_en,
  input  logic              cmp_bit,
  output logic              serial_out,
  output logic              busy,
  output logic              done,
  output logic              crc_match,
  output logic [CRC_W-1:0]  crc_out
);

  localparam int unsigned      CNT_W    = $clog2(CRC_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CRC_W - 1);

  crc_state_e       state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mism_q, mism_d;
  logic             cmp_q, cmp_d;
  logic             done_q, done_d;
  logic             match_q, match_d;
  logic [CRC_W-1:0] crc_beat;
  logic             mism_nxt;

  adbg_crc_step #(
    .CRC_W   (CRC_W),
    .DATA_W  (DATA_W),
    .POLY_REV(POLY_REV)
  ) u_step (
    .crc_in (crc_q),
    .data   (in_data),
    .crc_out(crc_beat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      crc_q   <= INIT;
      cnt_q   <= '0;
      mism_q  <= 1'b0;
      cmp_q   <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      mism_q  <= mism_d;
      cmp_q   <= cmp_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    cnt_d    = cnt_q;
    mism_d   = mism_q;
    cmp_d    = cmp_q;
    done_d   = 1'b0;
    match_d  = match_q;
    // Mismatch including the bit currently on crc[0], before it shifts away.
    mism_nxt = mism_q | (cmp_q & (cmp_bit ^ crc_q[0]));

    if (clr) begin
      state_d = ST_ACCUM;
      crc_d   = INIT;
      cnt_d   = '0;
      mism_d  = 1'b0;
      match_d = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          // A same-cycle beat is absorbed before the shift begins.
          if (in_valid) crc_d = crc_beat;
          if (shift_start) begin
            state_d = ST_SHIFT;
            cmp_d   = cmp_mode;
            mism_d  = 1'b0;
            match_d = 1'b0;
            cnt_d   = '0;
          end
        end
        ST_SHIFT: begin
          if (shift_en) begin
            mism_d = mism_nxt;
            if (cnt_q == LAST_CNT) begin
              state_d = ST_ACCUM;
              done_d  = 1'b1;
              match_d = cmp_q & ~mism_nxt;
              crc_d   = AUTO_RELOAD ? INIT : '0;
              cnt_d   = '0;
            end else begin
              crc_d = {1'b0, crc_q[CRC_W-1:1]};
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  always_comb begin
    in_ready   = (state_q == ST_ACCUM);
    busy       = (state_q == ST_SHIFT);
    serial_out = crc_q[0];
    done       = done_q;
    crc_match  = match_q;
    crc_out    = crc_q;
  end

endmodule

// File: tb/tb_adbg_crc_engine.sv
module tb_adbg_crc_engine;

  localparam logic [31:0] POLY = 32'hEDB88320;
  localparam logic [31:0] INIT = 32'hFFFFFFFF;

  logic       clk = 1'b0;
  logic       rst_n, clr, in_valid, shift_start, cmp_mode, shift_en, cmp_bit;
  logic [7:0] in_data8;

  // a_: DATA_W=1 reload, b_: DATA_W=8 reload, z_: DATA_W=1 no reload
  logic        a_in_ready, a_serial_out, a_busy, a_done, a_crc_match;
  logic [31:0] a_crc_out;
  logic        b_in_ready, b_serial_out, b_busy, b_done, b_crc_match;
  logic [31:0] b_crc_out;
  logic        z_in_ready, z_serial_out, z_busy, z_done, z_crc_match;
  logic [31:0] z_crc_out;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  adbg_crc_engine #(.DATA_W(1), .AUTO_RELOAD(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data8[0:0]),
    .in_ready(a_in_ready), .shift_start(shift_start), .cmp_mode(cmp_mode),
    .shift_en(shift_en), .cmp_bit(cmp_bit), .serial_out(a_serial_out), .busy(a_busy),
    .done(a_done), .crc_match(a_crc_match), .crc_out(a_crc_out));

  adbg_crc_engine #(.DATA_W(8), .AUTO_RELOAD(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data8),
    .in_ready(b_in_ready), .shift_start(shift_start), .cmp_mode(cmp_mode),
    .shift_en(shift_en), .cmp_bit(cmp_bit), .serial_out(b_serial_out), .busy(b_busy),
    .done(b_done), .crc_match(b_crc_match), .crc_out(b_crc_out));

  adbg_crc_engine #(.DATA_W(1), .AUTO_RELOAD(1'b0)) dut_z (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data8[0:0]),
    .in_ready(z_in_ready), .shift_start(shift_start), .cmp_mode(cmp_mode),
    .shift_en(shift_en), .cmp_bit(cmp_bit), .serial_out(z_serial_out), .busy(z_busy),
    .done(z_done), .crc_match(z_crc_match), .crc_out(z_crc_out));

  // Reference: reflected CRC, absorb nbits of d LSB-first.
  function automatic logic [31:0] m_crc(input logic [31:0] c, input logic [7:0] d,
                                        input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if ((c[0] ^ d[i]) == 1'b1) c = (c >> 1) ^ POLY;
      else c = c >> 1;
    end
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d);
    @(negedge clk); in_valid = 1'b1; in_data8 = d;
    @(negedge clk); in_valid = 1'b0;
  endtask

  // Start a shift (optionally with a same-cycle beat), pace shift_en and
  // collect serial bits of dut_a / dut_b until done plus a few cycles.
  task automatic do_shift(input logic cmp, input logic [31:0] cmpw, input logic with_beat,
                          input logic [7:0] beat_d, input logic rnd_pace, input logic junk,
                          output logic [31:0] w1, output logic [31:0] w8,
                          output int busy_n, output int done_n, output int rdy_viol);
    int  n = 0;
    int  post = 0;
    bit  phase = 1'b1;
    bit  go;
    w1 = '0; w8 = '0; busy_n = 0; done_n = 0; rdy_viol = 0;
    @(negedge clk);
    shift_start = 1'b1; cmp_mode = cmp; in_valid = with_beat; in_data8 = beat_d;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      shift_start = 1'b0;
      if (a_busy) busy_n++;
      if (a_busy && a_in_ready) rdy_viol++;
      if (a_done) done_n++;
      in_valid = junk && a_busy && ($urandom_range(0, 1) == 1);
      in_data8 = 8'($urandom);
      go = a_busy && (n < 32) && (rnd_pace ? ($urandom_range(0, 2) != 0) : phase);
      phase = ~phase;
      if (go) begin
        w1[n] = a_serial_out;
        w8[n] = b_serial_out;
        cmp_bit = cmpw[n];
        n++;
      end
      shift_en = go;
      if (done_n > 0) post++;
      if (post == 4) break;
    end
    shift_en = 1'b0; cmp_bit = 1'b0; in_valid = 1'b0;
  endtask

  typedef struct {
    logic        clr_b;
    logic [7:0]  din;
    logic [31:0] exp1;
    logic [31:0] exp8;
  } vec_t;

  vec_t vt[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] w1, w8, e1, e8, cmpw;
    logic [7:0]  bv;
    int          busy_n, done_n, rdy_viol, nb;
    logic        cmp;

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data8 = '0; shift_start = 1'b0;
    cmp_mode = 1'b0; shift_en = 1'b0; cmp_bit = 1'b0;

    // vector table: single beats from INIT, then the "123456789" chain
    vt[0] = '{1'b1, 8'h00, 32'h92477CDF, m_crc(INIT, 8'h00, 8)};
    vt[1] = '{1'b1, 8'h01, 32'h7FFFFFFF, m_crc(INIT, 8'h01, 8)};
    e1 = INIT; e8 = INIT;
    for (int i = 0; i < 9; i++) begin
      bv = 8'h31 + 8'(i);
      e1 = m_crc(e1, bv, 1);
      e8 = m_crc(e8, bv, 8);
      vt[2+i] = '{(i == 0), bv, e1, e8};
    end
    vt[10].exp8 = 32'h340BC6D9;
    vt[11] = '{1'b1, 8'hFF, m_crc(INIT, 8'hFF, 1), m_crc(INIT, 8'hFF, 8)};

    repeat (3) @(negedge clk);
    chk("reset_crc", a_crc_out, INIT);
    chk("reset_flags", 32'({a_in_ready, a_busy, a_done, a_crc_match, a_serial_out}), 32'b10001);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      if (vt[i].clr_b) pulse_clr();
      beat(vt[i].din);
      chk($sformatf("vec%0d_crc1", i), a_crc_out, vt[i].exp1);
      chk($sformatf("vec%0d_crc8", i), b_crc_out, vt[i].exp8);
    end

    // 72 single-bit beats of "123456789", back to back
    pulse_clr();
    for (int k = 0; k < 9; k++) begin
      bv = 8'h31 + 8'(k);
      for (int b = 0; b < 8; b++) begin
        @(negedge clk); in_valid = 1'b1; in_data8 = {7'b0, bv[b]};
      end
    end
    @(negedge clk); in_valid = 1'b0;
    chk("bitwise_check", a_crc_out, 32'h340BC6D9);

    // emit, shift_en every other cycle
    do_shift(1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, w1, w8, busy_n, done_n, rdy_viol);
    chk("emit_first8", 32'(w1[7:0]), 32'hD9);
    chk("emit_word", w1, 32'h340BC6D9);
    chk("emit_busy_cycles", 32'(busy_n), 32'd63);
    chk("emit_done_pulses", 32'(done_n), 32'd1);
    chk("emit_reload", a_crc_out, INIT);
    chk("emit_noreload", z_crc_out, 32'h0);
    chk("emit_match", 32'(a_crc_match), 32'd0);

    // compare, matching stream, junk beats during SHIFT
    pulse_clr();
    do_shift(1'b1, INIT, 1'b0, 8'h00, 1'b0, 1'b1, w1, w8, busy_n, done_n, rdy_viol);
    chk("cmp_match", 32'(a_crc_match), 32'd1);
    chk("cmp_match_nr", 32'(z_crc_match), 32'd1);
    chk("cmp_done", 32'(done_n), 32'd1);
    chk("cmp_ready_low", 32'(rdy_viol), 32'd0);
    chk("cmp_noreload", z_crc_out, 32'h0);
    chk("cmp_reload", a_crc_out, INIT);
    // async reset while idle clears the sticky match
    #2 rst_n = 1'b0;
    #1 chk("async_rst_match", 32'(a_crc_match), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // compare with bit 17 flipped
    pulse_clr();
    do_shift(1'b1, INIT ^ 32'h0002_0000, 1'b0, 8'h00, 1'b0, 1'b0, w1, w8, busy_n, done_n, rdy_viol);
    chk("cmp_flip17", 32'(a_crc_match), 32'd0);
    chk("cmp_flip17_done", 32'(done_n), 32'd1);

    // clr + in_valid at bit 10 aborts the shift
    pulse_clr();
    beat(8'h01);
    @(negedge clk); shift_start = 1'b1; cmp_mode = 1'b1;
    @(negedge clk); shift_start = 1'b0;
    repeat (10) begin shift_en = 1'b1; @(negedge clk); end
    clr = 1'b1; in_valid = 1'b1; in_data8 = 8'hA5; shift_en = 1'b1; shift_start = 1'b1;
    @(negedge clk); clr = 1'b0; in_valid = 1'b0; shift_en = 1'b0; shift_start = 1'b0;
    chk("abort_crc", a_crc_out, INIT);
    chk("abort_crc8", b_crc_out, INIT);
    chk("abort_flags", 32'({a_in_ready, a_busy, a_done, a_crc_match}), 32'b1000);
    done_n = 0;
    repeat (40) begin @(negedge clk); if (a_done) done_n++; end
    chk("abort_no_done", 32'(done_n), 32'd0);

    // async reset mid-SHIFT
    pulse_clr();
    beat(8'h00);
    @(negedge clk); shift_start = 1'b1; cmp_mode = 1'b0;
    @(negedge clk); shift_start = 1'b0;
    repeat (5) begin shift_en = 1'b1; @(negedge clk); end
    shift_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_crc", a_crc_out, INIT);
    chk("rst_mid_flags", 32'({a_in_ready, a_busy, a_done, a_crc_match, a_serial_out}), 32'b10001);
    @(negedge clk); rst_n = 1'b1;
    done_n = 0;
    repeat (10) begin @(negedge clk); if (a_done) done_n++; end
    chk("rst_mid_no_done", 32'(done_n), 32'd0);

    // same-cycle beat and shift_start; junk beats while shifting
    pulse_clr();
    do_shift(1'b0, 32'h0, 1'b1, 8'h00, 1'b0, 1'b1, w1, w8, busy_n, done_n, rdy_viol);
    chk("same_cycle_word", w1, 32'h92477CDF);
    chk("same_cycle_word8", w8, m_crc(INIT, 8'h00, 8));
    chk("same_cycle_ready", 32'(rdy_viol), 32'd0);

    // randomized transactions
    for (int it = 0; it < 25; it++) begin
      pulse_clr();
      e1 = INIT; e8 = INIT;
      nb = $urandom_range(1, 12);
      for (int k = 0; k < nb; k++) begin
        @(negedge clk);
        bv = 8'($urandom);
        in_data8 = bv;
        in_valid = ($urandom_range(0, 3) != 0);
        if (in_valid) begin
          e1 = m_crc(e1, bv, 1);
          e8 = m_crc(e8, bv, 8);
        end
      end
      @(negedge clk); in_valid = 1'b0;
      chk($sformatf("rnd%0d_crc1", it), a_crc_out, e1);
      chk($sformatf("rnd%0d_crc8", it), b_crc_out, e8);
      cmp = 1'($urandom_range(0, 1));
      cmpw = e1;
      if ($urandom_range(0, 1) == 1) cmpw[$urandom_range(0, 31)] ^= 1'b1;
      do_shift(cmp, cmpw, 1'b0, 8'h00, 1'b1, 1'b1, w1, w8, busy_n, done_n, rdy_viol);
      chk($sformatf("rnd%0d_word1", it), w1, e1);
      chk($sformatf("rnd%0d_word8", it), w8, e8);
      chk($sformatf("rnd%0d_match1", it), 32'(a_crc_match), 32'(cmp && (cmpw == e1)));
      chk($sformatf("rnd%0d_match8", it), 32'(b_crc_match), 32'(cmp && (cmpw == e8)));
      chk($sformatf("rnd%0d_done", it), 32'(done_n), 32'd1);
      chk($sformatf("rnd%0d_ready", it), 32'(rdy_viol), 32'd0);
      chk($sformatf("rnd%0d_reload", it), a_crc_out, INIT);
      chk($sformatf("rnd%0d_noreload", it), z_crc_out, 32'h0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
